issue_m: RTL and testbench
==========================

ISSUE_M -- requirements
Module: issue_m

Interface
Parameters:
REQ-001 The block SHALL have parameter REGW, default 4, matrix register index width.
REQ-002 The block SHALL have parameter TAGW, default 2, producer-tag width; tag 0 means "operand ready".
REQ-003 The block SHALL have parameter CNTW, default 8, stall-counter width.

Ports:
REQ-004 CLK  in  1  single clock, all state on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 fust_valid  in  1  matrix FUST row occupied and offered for issue.
REQ-007 fust_rd, fust_rs1, fust_rs2  in  REGW each  row register indices.
REQ-008 t1, t2  in  TAGW each  producer tags of rs1/rs2 at dispatch.
REQ-009 fust_spec  in  1  row dispatched under an unresolved branch.
REQ-010 wb_valid  in  1, wb_tag  in  TAGW  writeback broadcast of a completing producer.
REQ-011 flush  in  1, resolved  in  1  branch mispredict / branch resolved correct.
REQ-012 mu_ready  in  1, mu_done  in  1  matrix unit accepts op / finishes op.
REQ-013 busy  out  1  fed to FUST busy input; row held by this stage.
REQ-014 issue_valid  out  1, issue_rd/rs1/rs2  out  REGW each  op sent to matrix unit.
REQ-015 stall_cnt  out  CNTW  cycles current op has waited in WAIT.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, EXEC.
REQ-017 busy SHALL be 1 exactly when state is WAIT or EXEC.
REQ-018 IDLE & fust_valid: capture rd/rs1/rs2, spec=fust_spec; go WAIT next edge.
REQ-019 Capture: pend1=(t1!=0) & !(wb_valid & wb_tag==t1); pend2 likewise for t2 (same-cycle writeback bypass).
REQ-020 WAIT: wb_valid & wb_tag matches a pending tag clears that pend bit; one broadcast may clear both.
REQ-021 WAIT: resolved clears spec.
REQ-022 WAIT & flush & spec: go IDLE next edge; no issue; flush dominates resolved in the same cycle.
REQ-023 flush with spec=0, or in IDLE/EXEC, SHALL be ignored.
REQ-024 Issue condition in WAIT: !pend1 & !pend2 & !spec & mu_ready & !flush.
REQ-025 Issue condition true: issue_valid=1 that same cycle (combinational), issue_* = captured fields, go EXEC next edge.
REQ-026 Pend bits/spec cleared in a cycle SHALL only count from the next cycle (no same-cycle issue on wb or resolved in WAIT).
REQ-027 issue_valid SHALL be a single-cycle pulse per captured op; never asserted outside WAIT.
REQ-028 EXEC: mu_done goes IDLE next edge; fust_valid in that cycle is not captured (busy was 1); capture occurs the following cycle.
REQ-029 mu_done outside EXEC SHALL be ignored.
REQ-030 stall_cnt: cleared on capture; +1 each WAIT cycle without issue; saturates at all-ones; holds in EXEC; 0 in IDLE.
REQ-031 issue_* SHALL be 0 when issue_valid=0.

Reset
REQ-032 RST=1 SHALL immediately force state IDLE, busy=0, issue_valid=0, issue_*=0, stall_cnt=0, pend1=pend2=spec=0, regardless of state (incl. mid-EXEC).
REQ-033 First capture after RST deassert SHALL occur on the first edge with fust_valid=1.

Verification
REQ-034 Ready ops: fust_valid=1, t1=t2=0, spec=0, mu_ready=1 -> busy=1 cycle 1, issue_valid pulse cycle 1 with captured rd/rs1/rs2, EXEC cycle 2; mu_done cycle 5 -> busy=0 cycle 6.
REQ-035 Tag wait: t1=2, t2=3; wb_tag=2 at cycle 3, wb_tag=3 at cycle 6 -> issue_valid at cycle 7, stall_cnt=6 at issue.
REQ-036 Bypass: t1=1 with wb_valid=1, wb_tag=1 in capture cycle, t2=0 -> issue cycle 1, stall_cnt=0.
REQ-037 Speculation: fust_spec=1, operands ready; resolved cycle 4 -> issue cycle 5; repeat with flush and resolved both at cycle 4 -> no issue, busy=0 cycle 5.
REQ-038 Backpressure/saturation: operands ready, mu_ready=0 for 300 cycles (CNTW=8) -> stall_cnt stops at 255, issue on first mu_ready=1.
REQ-039 Reset mid-EXEC: RST pulse while in EXEC -> busy=0, issue_valid=0 asynchronously; later mu_done ignored; next fust_valid captured normally.

Source files
------------

// File: rtl/issue_m.sv
// Issue stage between the FUST and the matrix unit: holds one op until its
// producer tags have written back and any branch it depends on has resolved.
module issue_m #(
   parameter int unsigned REGW = 4,
   parameter int unsigned TAGW = 2,
   parameter int unsigned CNTW = 8
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            fust_valid,
   input  logic [REGW-1:0] fust_rd,
   input  logic [REGW-1:0] fust_rs1,
   input  logic [REGW-1:0] fust_rs2,
   input  logic [TAGW-1:0] t1,
   input  logic [TAGW-1:0] t2,
   input  logic            fust_spec,
   input  logic            wb_valid,
   input  logic [TAGW-1:0] wb_tag,
   input  logic            flush,
   input  logic            resolved,
   input  logic            mu_ready,
   input  logic            mu_done,
   output logic            busy,
   output logic            issue_valid,
   output logic [REGW-1:0] issue_rd,
   output logic [REGW-1:0] issue_rs1,
   output logic [REGW-1:0] issue_rs2,
   output logic [CNTW-1:0] stall_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT, EXEC} state_t;

   state_t          state_q, state_n;
   logic [REGW-1:0] rd_q, rs1_q, rs2_q, rd_n, rs1_n, rs2_n;
   logic [TAGW-1:0] tag1_q, tag2_q, tag1_n, tag2_n;
   logic            pend1_q, pend2_q, spec_q, pend1_n, pend2_n, spec_n;
   logic [CNTW-1:0] cnt_q, cnt_n;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         tag1_q  <= '0;
         tag2_q  <= '0;
         pend1_q <= 1'b0;
         pend2_q <= 1'b0;
         spec_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         rd_q    <= rd_n;
         rs1_q   <= rs1_n;
         rs2_q   <= rs2_n;
         tag1_q  <= tag1_n;
         tag2_q  <= tag2_n;
         pend1_q <= pend1_n;
         pend2_q <= pend2_n;
         spec_q  <= spec_n;
         cnt_q   <= cnt_n;
      end
   end

   always_comb begin
      state_n     = state_q;
      rd_n        = rd_q;
      rs1_n       = rs1_q;
      rs2_n       = rs2_q;
      tag1_n      = tag1_q;
      tag2_n      = tag2_q;
      pend1_n     = pend1_q;
      pend2_n     = pend2_q;
      spec_n      = spec_q;
      cnt_n       = cnt_q;
      issue_valid = 1'b0;
      issue_rd    = '0;
      issue_rs1   = '0;
      issue_rs2   = '0;
      busy        = (state_q != IDLE);
      stall_cnt   = cnt_q;

      case (state_q)
         IDLE: begin
            if (fust_valid) begin
               rd_n    = fust_rd;
               rs1_n   = fust_rs1;
               rs2_n   = fust_rs2;
               tag1_n  = t1;
               tag2_n  = t2;
               // A producer writing back in the capture cycle is already done.
               pend1_n = (t1 != '0) && !(wb_valid && (wb_tag == t1));
               pend2_n = (t2 != '0) && !(wb_valid && (wb_tag == t2));
               spec_n  = fust_spec;
               cnt_n   = '0;
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (flush && spec_q) begin
               state_n = IDLE;
               pend1_n = 1'b0;
               pend2_n = 1'b0;
               spec_n  = 1'b0;
               cnt_n   = '0;
            end else if (!pend1_q && !pend2_q && !spec_q && mu_ready && !flush) begin
               issue_valid = 1'b1;
               issue_rd    = rd_q;
               issue_rs1   = rs1_q;
               issue_rs2   = rs2_q;
               state_n     = EXEC;
            end else begin
               // Clears land in the registers, so they enable issue only next cycle.
               if (wb_valid && (wb_tag == tag1_q)) pend1_n = 1'b0;
               if (wb_valid && (wb_tag == tag2_q)) pend2_n = 1'b0;
               if (resolved) spec_n = 1'b0;
               if (cnt_q != '1) cnt_n = cnt_q + CNTW'(1);
            end
         end
         EXEC: begin
            if (mu_done) begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_issue_m.sv
// Directed bench for issue_m: stimulus pushes expected issue transactions,
// a negedge monitor pops and compares them whenever issue_valid is seen.
module tb_issue_m;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       fust_valid = 1'b0;
   logic [3:0] fust_rd = '0, fust_rs1 = '0, fust_rs2 = '0;
   logic [1:0] t1 = '0, t2 = '0;
   logic       fust_spec = 1'b0;
   logic       wb_valid = 1'b0;
   logic [1:0] wb_tag = '0;
   logic       flush = 1'b0, resolved = 1'b0;
   logic       mu_ready = 1'b1, mu_done = 1'b0;
   logic       busy, issue_valid;
   logic [3:0] issue_rd, issue_rs1, issue_rs2;
   logic [7:0] stall_cnt;

   typedef struct packed {
      logic [3:0] rd;
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic [7:0] st;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   issue_m #(.REGW(4), .TAGW(2), .CNTW(8)) dut (
      .CLK(CLK), .RST(RST),
      .fust_valid(fust_valid), .fust_rd(fust_rd), .fust_rs1(fust_rs1), .fust_rs2(fust_rs2),
      .t1(t1), .t2(t2), .fust_spec(fust_spec),
      .wb_valid(wb_valid), .wb_tag(wb_tag),
      .flush(flush), .resolved(resolved),
      .mu_ready(mu_ready), .mu_done(mu_done),
      .busy(busy), .issue_valid(issue_valid),
      .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic quiet();
      fust_valid = 1'b0; fust_spec = 1'b0;
      t1 = '0; t2 = '0;
      wb_valid = 1'b0; wb_tag = '0;
      flush = 1'b0; resolved = 1'b0;
      mu_ready = 1'b1; mu_done = 1'b0;
   endtask

   task automatic capture(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [1:0] a, input logic [1:0] b, input logic sp);
      fust_valid = 1'b1;
      fust_rd = rd; fust_rs1 = rs1; fust_rs2 = rs2;
      t1 = a; t2 = b; fust_spec = sp;
   endtask

   // Monitor: scoreboard pop on every issue, zero-field check otherwise.
   always @(negedge CLK) begin
      if (!RST) begin
         if (issue_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue: got rd=%0d rs1=%0d rs2=%0d expected none at %0t",
                        issue_rd, issue_rs1, issue_rs2, $time);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("issue_rd", int'(issue_rd), int'(e.rd));
               chk("issue_rs1", int'(issue_rs1), int'(e.rs1));
               chk("issue_rs2", int'(issue_rs2), int'(e.rs2));
               chk("issue_stall", int'(stall_cnt), int'(e.st));
            end
         end else begin
            chk("idle_fields_zero", int'({issue_rd, issue_rs1, issue_rs2}), 0);
         end
      end
   end

   initial begin
      quiet();
      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_issue_valid", int'(issue_valid), 0);
      chk("rst_stall", int'(stall_cnt), 0);
      step();
      step();
      RST = 1'b0;

      // Ready op: issue in cycle 1, EXEC, done in cycle 5; fust_valid during EXEC/done ignored.
      capture(4'd5, 4'd6, 4'd7, 2'd0, 2'd0, 1'b0);
      q.push_back('{rd: 4'd5, rs1: 4'd6, rs2: 4'd7, st: 8'd0});
      step(); fust_valid = 1'b0;                      // cycle 1
      @(negedge CLK); chk("s1_busy_c1", int'(busy), 1); chk("s1_issue_c1", int'(issue_valid), 1);
      step();                                          // cycle 2
      @(negedge CLK); chk("s1_busy_c2", int'(busy), 1); chk("s1_noissue_c2", int'(issue_valid), 0);
      step();                                          // cycle 3
      @(negedge CLK); chk("s1_stall_exec", int'(stall_cnt), 0);
      step();                                          // cycle 4
      step(); mu_done = 1'b1; capture(4'd15, 4'd14, 4'd13, 2'd0, 2'd0, 1'b0); // cycle 5
      step(); quiet();                                 // cycle 6
      @(negedge CLK); chk("s1_busy_c6", int'(busy), 0);
      step();

      // Tag wait: pend1 cleared by wb in cycle 3, pend2 in cycle 6; non-spec flush ignored.
      capture(4'd1, 4'd2, 4'd3, 2'd2, 2'd3, 1'b0);
      q.push_back('{rd: 4'd1, rs1: 4'd2, rs2: 4'd3, st: 8'd6});
      step(); quiet();                                 // cycle 1
      step(); flush = 1'b1;                            // cycle 2
      step(); quiet(); wb_valid = 1'b1; wb_tag = 2'd2; // cycle 3
      @(negedge CLK); chk("s2_noissue_c3", int'(issue_valid), 0);
      step(); quiet();                                 // cycle 4
      @(negedge CLK); chk("s2_stall_c4", int'(stall_cnt), 3); chk("s2_busy_c4", int'(busy), 1);
      step();                                          // cycle 5
      step(); wb_valid = 1'b1; wb_tag = 2'd3;          // cycle 6
      @(negedge CLK); chk("s2_noissue_c6", int'(issue_valid), 0);
      step(); quiet();                                 // cycle 7
      @(negedge CLK); chk("s2_issue_c7", int'(issue_valid), 1);
      step(); mu_done = 1'b1;                          // cycle 8
      step(); quiet();                                 // cycle 9
      @(negedge CLK); chk("s2_busy_done", int'(busy), 0);
      step();

      // Same-cycle writeback bypass at capture.
      capture(4'd9, 4'd10, 4'd11, 2'd1, 2'd0, 1'b0);
      wb_valid = 1'b1; wb_tag = 2'd1;
      q.push_back('{rd: 4'd9, rs1: 4'd10, rs2: 4'd11, st: 8'd0});
      step(); quiet();                                 // cycle 1
      @(negedge CLK); chk("s3_bypass_issue", int'(issue_valid), 1);
      step(); mu_done = 1'b1;
      step(); quiet();
      @(negedge CLK); chk("s3_busy_done", int'(busy), 0);
      step();

      // One broadcast clears both pend bits.
      capture(4'd4, 4'd8, 4'd12, 2'd2, 2'd2, 1'b0);
      q.push_back('{rd: 4'd4, rs1: 4'd8, rs2: 4'd12, st: 8'd2});
      step(); quiet();                                 // cycle 1
      step(); wb_valid = 1'b1; wb_tag = 2'd2;          // cycle 2
      step(); quiet();                                 // cycle 3
      @(negedge CLK); chk("s3b_issue_c3", int'(issue_valid), 1);
      step(); mu_done = 1'b1;
      step(); quiet();
      step();

      // Speculative op, resolved in cycle 4, issues in cycle 5.
      capture(4'd12, 4'd13, 4'd14, 2'd0, 2'd0, 1'b1);
      q.push_back('{rd: 4'd12, rs1: 4'd13, rs2: 4'd14, st: 8'd4});
      step(); quiet();                                 // cycle 1
      step(); step();                                  // cycle 3
      step(); resolved = 1'b1;                         // cycle 4
      @(negedge CLK); chk("s4_noissue_c4", int'(issue_valid), 0);
      step(); quiet();                                 // cycle 5
      @(negedge CLK); chk("s4_issue_c5", int'(issue_valid), 1);
      step(); mu_done = 1'b1;
      step(); quiet();
      step();

      // Speculative op flushed with resolve in the same cycle: dropped.
      capture(4'd7, 4'd7, 4'd7, 2'd0, 2'd0, 1'b1);
      step(); quiet();                                 // cycle 1
      step(); step();                                  // cycle 3
      step(); flush = 1'b1; resolved = 1'b1;           // cycle 4
      step(); quiet();                                 // cycle 5
      @(negedge CLK); chk("s4b_busy_flushed", int'(busy), 0);
      step(); step();

      // Backpressure: stall counter saturates at 255.
      capture(4'd3, 4'd4, 4'd5, 2'd0, 2'd0, 1'b0);
      mu_ready = 1'b0;
      q.push_back('{rd: 4'd3, rs1: 4'd4, rs2: 4'd5, st: 8'd255});
      for (int c = 1; c <= 300; c++) begin
         step();
         fust_valid = 1'b0;
         if (c == 100) begin @(negedge CLK); chk("s5_stall_c100", int'(stall_cnt), 99); end
         if (c == 256) begin @(negedge CLK); chk("s5_stall_c256", int'(stall_cnt), 255); end
         if (c == 300) begin @(negedge CLK); chk("s5_stall_sat", int'(stall_cnt), 255); end
      end
      step(); mu_ready = 1'b1;                         // cycle 301
      @(negedge CLK); chk("s5_issue", int'(issue_valid), 1);
      step(); mu_done = 1'b1;
      step(); quiet();
      step();

      // Asynchronous reset during EXEC; stray mu_done ignored; next capture normal.
      capture(4'd2, 4'd3, 4'd4, 2'd0, 2'd0, 1'b0);
      q.push_back('{rd: 4'd2, rs1: 4'd3, rs2: 4'd4, st: 8'd0});
      step(); quiet();                                 // cycle 1 (issue)
      step();                                          // cycle 2 (EXEC)
      @(negedge CLK); chk("s6_busy_exec", int'(busy), 1);
      #1 RST = 1'b1;
      #1;
      chk("s6_rst_busy", int'(busy), 0);
      chk("s6_rst_issue", int'(issue_valid), 0);
      chk("s6_rst_stall", int'(stall_cnt), 0);
      step();
      RST = 1'b0;
      mu_done = 1'b1;
      @(negedge CLK); chk("s6_done_ignored", int'(busy), 0);
      step(); quiet();
      capture(4'd6, 4'd7, 4'd8, 2'd0, 2'd0, 1'b0);
      q.push_back('{rd: 4'd6, rs1: 4'd7, rs2: 4'd8, st: 8'd0});
      step(); quiet();
      @(negedge CLK); chk("s6_recapture_busy", int'(busy), 1); chk("s6_recapture_issue", int'(issue_valid), 1);
      step(); mu_done = 1'b1;
      step(); quiet();
      @(negedge CLK); chk("s6_busy_done", int'(busy), 0);
      step(); step();

      chk("scoreboard_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
